multi_ball_engine: RTL and testbench

//  Parametrised successor to the single-ball motion block: moves NUM_BALLS balls per frame, each with its own

---
 rtl/multi_ball_engine.sv | 187 ++++++++++++++++++
 tb/tb_multi_ball_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ball_engine.sv
// multi_ball_engine
//   Moves NUM_BALLS balls once per video frame. Each ball has its own position
//   and motion and bounces off the screen edges. The ball picked by sel is
//   steered by the USB keycode (W/A/S/D). One shared update datapath visits one
//   ball per Clk. Results go into working registers, and all of them are copied
//   to BallX/BallY in a single COMMIT cycle, so the colour mapper never sees a
//   half-updated frame.
//
// Ports
//   Clk, Reset      system clock; asynchronous active-high reset
//   frame_vs        VGA vertical sync (asynchronous); its rising edge starts a sweep
//   keycode         current USB keycode, 0 = no key; sampled during each ball's cycle
//   sel             index of the steered ball; values >= NUM_BALLS steer no ball
//   pause           1 = hold position/motion of the ball being visited
//   BallX, BallY    packed committed centres, ball i at [i*COORD_W +: COORD_W]
//   BallS           constant ball half-size
//   busy            high while a sweep (UPDATE or COMMIT) is in progress
//   frame_done      one-cycle strobe in the cycle after the commit lands
//   overrun         sticky: a frame tick arrived while busy (cleared by Reset)
//   dbg_state       current FSM state (IDLE=0, UPDATE=1, COMMIT=2)
//
// Output handshake: frame_done acts as a valid strobe with no ready. BallX/BallY
// change only on the edge that raises frame_done. They hold steady until the
// next frame_done.
module multi_ball_engine #(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  parameter logic [7:0] KEY_W = 8'h1A,
  parameter logic [7:0] KEY_A = 8'h04,
  parameter logic [7:0] KEY_S = 8'h16,
  parameter logic [7:0] KEY_D = 8'h07,
  localparam int IDX_W    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_vs,
  input  logic [7:0]                     keycode,
  input  logic [IDX_W-1:0]               sel,
  input  logic                           pause,
  output logic [NUM_BALLS*COORD_W-1:0]   BallX,
  output logic [NUM_BALLS*COORD_W-1:0]   BallY,
  output logic [COORD_W-1:0]             BallS,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] POS_STEP = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] NEG_STEP = COORD_W'(-STEP);
  localparam logic [COORD_W-1:0] INIT_Y   = COORD_W'((Y_MIN + Y_MAX) / 2);

  // Bounce limits are compared one bit wider than the coordinates. That way
  // x+BALL_SIZE cannot wrap around. The low-side test is written as
  // x <= MIN+BALL_SIZE, so an underflowing x-BALL_SIZE still counts as a hit.
  localparam logic [COORD_W:0] BS_E   = (COORD_W+1)'(BALL_SIZE);
  localparam logic [COORD_W:0] XMAX_E = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] YMAX_E = (COORD_W+1)'(Y_MAX);
  localparam logic [COORD_W:0] XLO_E  = (COORD_W+1)'(X_MIN + BALL_SIZE);
  localparam logic [COORD_W:0] YLO_E  = (COORD_W+1)'(Y_MIN + BALL_SIZE);

  function automatic logic [COORD_W-1:0] init_x(input int i);
    return COORD_W'(X_MIN + ((i + 1) * (X_MAX - X_MIN)) / (NUM_BALLS + 1));
  endfunction

  function automatic logic [COORD_W-1:0] init_mx(input int i);
    return (i % 2 == 0) ? POS_STEP : NEG_STEP;
  endfunction

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic vs_s1, vs_s2, vs_s3;
  logic tick, last;

  logic [COORD_W-1:0] wx  [NUM_BALLS];
  logic [COORD_W-1:0] wy  [NUM_BALLS];
  logic [COORD_W-1:0] wmx [NUM_BALLS];
  logic [COORD_W-1:0] wmy [NUM_BALLS];
  logic [COORD_W-1:0] bx  [NUM_BALLS];
  logic [COORD_W-1:0] by  [NUM_BALLS];

  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y, nxt_mx, nxt_my;

  // vs_s1/vs_s2 form the synchroniser. vs_s3 is one cycle behind vs_s2 and is
  // used only to find the rising edge.
  assign tick      = vs_s2 & ~vs_s3;
  assign last      = (idx == IDX_W'(NUM_BALLS - 1));
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign BallS     = COORD_W'(BALL_SIZE);

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
    assign BallX[g*COORD_W +: COORD_W] = bx[g];
    assign BallY[g*COORD_W +: COORD_W] = by[g];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tick) state_nxt = S_UPDATE;
      S_UPDATE: if (last) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Shared update datapath for the ball selected by idx. Steering is applied
  // first, and a wall hit then overrides it.
  always_comb begin
    cur_x  = wx[idx];
    cur_y  = wy[idx];
    nxt_mx = wmx[idx];
    nxt_my = wmy[idx];
    if (idx == sel) begin
      case (keycode)
        KEY_W:   begin nxt_mx = '0;       nxt_my = NEG_STEP; end
        KEY_A:   begin nxt_mx = NEG_STEP; nxt_my = '0;       end
        KEY_S:   begin nxt_mx = '0;       nxt_my = POS_STEP; end
        KEY_D:   begin nxt_mx = POS_STEP; nxt_my = '0;       end
        default: ;
      endcase
    end
    if ({1'b0, cur_y} + BS_E >= YMAX_E) nxt_my = NEG_STEP;
    if ({1'b0, cur_y} <= YLO_E)         nxt_my = POS_STEP;
    if ({1'b0, cur_x} + BS_E >= XMAX_E) nxt_mx = NEG_STEP;
    if ({1'b0, cur_x} <= XLO_E)         nxt_mx = POS_STEP;
    nxt_x = cur_x + nxt_mx;
    nxt_y = cur_y + nxt_my;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s3      <= 1'b0;
      state      <= S_IDLE;
      idx        <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        wx[i]  <= init_x(i);
        wy[i]  <= INIT_Y;
        wmx[i] <= init_mx(i);
        wmy[i] <= POS_STEP;
        bx[i]  <= init_x(i);
        by[i]  <= INIT_Y;
      end
    end else begin
      vs_s1      <= frame_vs;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      state      <= state_nxt;
      frame_done <= (state == S_COMMIT);
      if (tick && state != S_IDLE) overrun <= 1'b1;
      if (state == S_UPDATE) begin
        idx <= last ? '0 : idx + 1'b1;
        if (!pause) begin
          wx[idx]  <= nxt_x;
          wy[idx]  <= nxt_y;
          wmx[idx] <= nxt_mx;
          wmy[idx] <= nxt_my;
        end
      end else begin
        idx <= '0;
      end
      if (state == S_COMMIT) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          bx[i] <= wx[i];
          by[i] <= wy[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_ball_engine.sv
`timescale 1ns/1ps
module tb_multi_ball_engine;

  localparam int N    = 4;
  localparam int W    = 10;
  localparam int IW   = 2;
  localparam int XMIN = 0;
  localparam int XMAX = 639;
  localparam int YMIN = 0;
  localparam int YMAX = 479;
  localparam int BS   = 4;
  localparam int STEP = 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic frame_vs;
  logic [7:0] keycode;
  logic [IW-1:0] sel;
  logic pause;
  logic [N*W-1:0] ball_x, ball_y;
  logic [W-1:0] ball_s;
  logic busy, frame_done, overrun;
  logic [1:0] dbg_state;

  logic [W-1:0] b1_x, b1_y, b1_s;
  logic b1_busy, b1_fd, b1_ovr;
  logic [1:0] b1_dbg;
  logic [0:0] b1_sel;
  logic [7*W-1:0] b7_x, b7_y;
  logic [W-1:0] b7_s;
  logic b7_busy, b7_fd, b7_ovr;
  logic [1:0] b7_dbg;
  logic [2:0] b7_sel;

  always #10 clk = ~clk;

  multi_ball_engine #(.NUM_BALLS(N)) dut (
    .Clk(clk), .Reset(rst), .frame_vs(frame_vs), .keycode(keycode), .sel(sel),
    .pause(pause), .BallX(ball_x), .BallY(ball_y), .BallS(ball_s), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  multi_ball_engine #(.NUM_BALLS(1)) dut1 (
    .Clk(clk), .Reset(rst), .frame_vs(frame_vs), .keycode(8'h00), .sel(b1_sel),
    .pause(1'b0), .BallX(b1_x), .BallY(b1_y), .BallS(b1_s), .busy(b1_busy),
    .frame_done(b1_fd), .overrun(b1_ovr), .dbg_state(b1_dbg)
  );

  multi_ball_engine #(.NUM_BALLS(7)) dut7 (
    .Clk(clk), .Reset(rst), .frame_vs(frame_vs), .keycode(8'h00), .sel(b7_sel),
    .pause(1'b0), .BallX(b7_x), .BallY(b7_y), .BallS(b7_s), .busy(b7_busy),
    .frame_done(b7_fd), .overrun(b7_ovr), .dbg_state(b7_dbg)
  );

  // ---------------- reference model ----------------
  int m_x[N], m_y[N], m_mx[N], m_my[N];
  bit exp_ovr;
  logic [2*N*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;
  int busy_cnt = 0;

  function automatic int init_x(input int n, input int i);
    return XMIN + ((i + 1) * (XMAX - XMIN)) / (n + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i]  = init_x(N, i);
      m_y[i]  = (YMIN + YMAX) / 2;
      m_mx[i] = (i % 2 == 0) ? STEP : -STEP;
      m_my[i] = STEP;
    end
    exp_ovr = 1'b0;
  endtask

  // One whole frame in plain integer arithmetic.
  task automatic model_frame(input logic [7:0] kc, input int s, input bit p);
    if (p) return;
    for (int i = 0; i < N; i++) begin
      if (i == s) begin
        case (kc)
          8'h1A: begin m_mx[i] = 0;     m_my[i] = -STEP; end
          8'h04: begin m_mx[i] = -STEP; m_my[i] = 0;     end
          8'h16: begin m_mx[i] = 0;     m_my[i] = STEP;  end
          8'h07: begin m_mx[i] = STEP;  m_my[i] = 0;     end
          default: ;
        endcase
      end
      if (m_y[i] + BS >= YMAX) m_my[i] = -STEP;
      if (m_y[i] - BS <= YMIN) m_my[i] = STEP;
      if (m_x[i] + BS >= XMAX) m_mx[i] = -STEP;
      if (m_x[i] - BS <= XMIN) m_mx[i] = STEP;
      m_x[i] = (m_x[i] + m_mx[i]) & ((1 << W) - 1);
      m_y[i] = (m_y[i] + m_my[i]) & ((1 << W) - 1);
    end
  endtask

  function automatic logic [2*N*W-1:0] model_pack();
    logic [2*N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W]     = W'(m_x[i]);
      r[N*W + i*W +: W] = W'(m_y[i]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (frame_done) begin
        fd_count++;
        check("latency", busy_cnt, N + 1);
        busy_cnt = 0;
        check("busy_at_done", busy, 1'b0);
        check("overrun", overrun, exp_ovr);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got frame_done with empty queue at %0t", $time);
        end else begin
          check("ball_xy", {ball_y, ball_x}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int start);
    int t;
    t = 0;
    while (fd_count == start && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    check("frame_timeout", fd_count != start, 1'b1);
  endtask

  task automatic do_frame(input logic [7:0] kc, input int s, input bit p);
    int start;
    @(negedge clk); #1;
    keycode = kc;
    sel     = IW'(s);
    pause   = p;
    model_frame(kc, s, p);
    exp_q.push_back(model_pack());
    start    = fd_count;
    frame_vs = 1'b1;
    repeat (2) @(negedge clk);
    #1 frame_vs = 1'b0;
    wait_done(start);
  endtask

  task automatic wait_busy();
    int t;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_xy"}, {ball_y, ball_x}, model_pack());
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] kc_tab [8];
  initial begin
    int start;
    kc_tab[0] = 8'h00; kc_tab[1] = 8'h00; kc_tab[2] = 8'h00; kc_tab[3] = 8'h1A;
    kc_tab[4] = 8'h04; kc_tab[5] = 8'h16; kc_tab[6] = 8'h07; kc_tab[7] = 8'h55;
    rst = 1'b1; frame_vs = 1'b0; keycode = 8'h00; sel = '0; pause = 1'b0;
    b1_sel = '0; b7_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("ball_s", ball_s, BS);
    check("b1_reset_x", b1_x, init_x(1, 0));
    check("b7_reset_x6", b7_x[6*W +: W], init_x(7, 6));
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // First frame, no key: also compare the 1- and 7-ball builds.
    do_frame(8'h00, 0, 1'b0);
    repeat (8) @(negedge clk);
    check("b1_x", b1_x, init_x(1, 0) + STEP);
    check("b1_y", b1_y, (YMIN + YMAX) / 2 + STEP);
    for (int i = 0; i < 7; i++) begin
      check("b7_x", b7_x[i*W +: W], init_x(7, i) + ((i % 2 == 0) ? STEP : -STEP));
      check("b7_y", b7_y[i*W +: W], (YMIN + YMAX) / 2 + STEP);
    end

    // Steer ball 2 up.
    do_frame(8'h1A, 2, 1'b0);

    // Paused frames still complete.
    start = fd_count;
    for (int k = 0; k < 3; k++) do_frame(kc_tab[$urandom_range(0, 7)], $urandom_range(0, N - 1), 1'b1);
    check("pause_done_count", fd_count - start, 3);

    // A second edge while busy: overrun set, only one frame_done.
    @(negedge clk); #1;
    keycode = 8'h00; sel = '0; pause = 1'b0;
    model_frame(8'h00, 0, 1'b0);
    exp_q.push_back(model_pack());
    start = fd_count;
    frame_vs = 1'b1;
    wait_busy();
    frame_vs = 1'b0;
    @(negedge clk);
    exp_ovr  = 1'b1;
    frame_vs = 1'b1;
    wait_done(start);
    frame_vs = 1'b0;
    repeat (15) @(negedge clk);
    check("overrun_single_done", fd_count - start, 1);
    check("overrun_sticky", overrun, 1'b1);

    // Drive ball 0 right into the wall while holding D.
    for (int k = 0; k < 520; k++) do_frame(8'h07, 0, 1'b0);

    // Randomised frames.
    for (int k = 0; k < 150; k++)
      do_frame(kc_tab[$urandom_range(0, 7)], $urandom_range(0, N - 1), ($urandom_range(0, 7) == 0));

    // Reset in the middle of a sweep, at idx 2.
    @(negedge clk); #1;
    keycode = 8'h00; sel = '0; pause = 1'b0;
    frame_vs = 1'b1;
    wait_busy();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    frame_vs = 1'b0;
    #1;
    model_reset();
    check_reset_state("mid_reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    start = fd_count;
    repeat (10) @(negedge clk);
    check("no_partial_commit", fd_count - start, 0);
    do_frame(8'h16, 1, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
